// File: rtl/pxs_sync_gen_pkg.sv
// Shared definitions for the PixelStream sync generator: stream field layout,
// colour constants, default 640x480@60 timing and the pattern-mode encoding.
package pxs_sync_gen_pkg;

    localparam int CNT_W    = 10;
    localparam int STREAM_W = 26;

    // Stream layout, MSB first: HS, VS, XC[9:0], YC[9:0], Active, RGB[2:0]
    localparam int HS_BIT     = 25;
    localparam int VS_BIT     = 24;
    localparam int XC_LSB     = 14;
    localparam int YC_LSB     = 4;
    localparam int ACTIVE_BIT = 3;
    localparam int RGB_LSB    = 0;
    localparam int RGB_W      = 3;

    localparam logic [RGB_W-1:0] COL_BLACK = 3'b000;
    localparam logic [RGB_W-1:0] COL_BLUE  = 3'b001;
    localparam logic [RGB_W-1:0] COL_GREEN = 3'b010;
    localparam logic [RGB_W-1:0] COL_PINK  = 3'b101;
    localparam logic [RGB_W-1:0] COL_WHITE = 3'b111;

    localparam int H_TOTAL_DEF  = 800;
    localparam int V_TOTAL_DEF  = 525;
    localparam int HS_START_DEF = 656;
    localparam int HS_END_DEF   = 751;
    localparam int VS_START_DEF = 490;
    localparam int VS_END_DEF   = 491;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_ANIM    = 2'd3
    } pattern_mode_e;

    function automatic logic [STREAM_W-1:0] pack_stream(
        input logic             hs,
        input logic             vs,
        input logic [CNT_W-1:0] xc,
        input logic [CNT_W-1:0] yc,
        input logic             active,
        input logic [RGB_W-1:0] rgb
    );
        return {hs, vs, xc, yc, active, rgb};
    endfunction

endpackage

// File: rtl/pxs_pattern_gen.sv
// Test-pattern background for the sync generator: latches mode/colour at the
// frame boundary and produces the RGB for the current raster position.
module pxs_pattern_gen
    import pxs_sync_gen_pkg::*;
#(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned H_TOTAL   = 800,
    parameter int unsigned BAR_WIDTH = 80,
    parameter int unsigned CHECK_BIT = 5
) (
    input  logic             px_clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] hcnt_i,
    input  logic [CNT_W-1:0] vcnt_i,
    input  logic             frame_wrap_i,
    input  logic [2:0]       frame_lsb_i,
    input  logic [1:0]       mode_i,
    input  logic [2:0]       color_i,
    output logic [RGB_W-1:0] rgb_o
);

    localparam int unsigned BAR_PIX_W = $clog2(BAR_WIDTH + 1);

    pattern_mode_e          mode_q, mode_d;
    logic [RGB_W-1:0]       color_q, color_d;
    logic [2:0]             bar_idx_q, bar_idx_d;
    logic [BAR_PIX_W-1:0]   bar_pix_q, bar_pix_d;
    logic                   visible;

    always_comb begin
        mode_d    = mode_q;
        color_d   = color_q;
        bar_idx_d = bar_idx_q;
        bar_pix_d = bar_pix_q;
        if (frame_wrap_i) begin
            mode_d  = pattern_mode_e'(mode_i);
            color_d = color_i;
        end
        // Bar state always describes the pixel currently at hcnt_i.
        if (hcnt_i == CNT_W'(H_TOTAL - 1)) begin
            bar_idx_d = '0;
            bar_pix_d = '0;
        end else if (hcnt_i < CNT_W'(H_VISIBLE)) begin
            if (bar_pix_q == BAR_PIX_W'(BAR_WIDTH - 1)) begin
                bar_pix_d = '0;
                if (bar_idx_q != 3'd7) begin
                    bar_idx_d = bar_idx_q + 3'd1;
                end
            end else begin
                bar_pix_d = bar_pix_q + 1'b1;
            end
        end
    end

    always_comb begin
        visible = (hcnt_i < CNT_W'(H_VISIBLE)) && (vcnt_i < CNT_W'(V_VISIBLE));
        rgb_o   = COL_BLACK;
        if (visible) begin
            case (mode_q)
                MODE_SOLID:   rgb_o = color_q;
                MODE_BARS:    rgb_o = bar_idx_q;
                MODE_CHECKER: rgb_o = (hcnt_i[CHECK_BIT] ^ vcnt_i[CHECK_BIT]) ? COL_WHITE : COL_BLACK;
                MODE_ANIM:    rgb_o = hcnt_i[5:3] + frame_lsb_i;
                default:      rgb_o = COL_BLACK;
            endcase
        end
    end

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_SOLID;
            color_q   <= COL_BLACK;
            bar_idx_q <= '0;
            bar_pix_q <= '0;
        end else begin
            mode_q    <= mode_d;
            color_q   <= color_d;
            bar_idx_q <= bar_idx_d;
            bar_pix_q <= bar_pix_d;
        end
    end

endmodule

// File: rtl/pxs_sync_gen.sv
// Head of the PixelStream pipeline: raster counters, sync/active decode and the
// registered RGBStr output with a test-pattern background and frame counter.
module pxs_sync_gen
    import pxs_sync_gen_pkg::*;
#(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        SYNC_POL  = 1'b0,
    parameter int unsigned BAR_WIDTH = 80,
    parameter int unsigned CHECK_BIT = 5
) (
    input  logic                px_clk,
    input  logic                rst,
    input  logic [1:0]          mode_i,
    input  logic [2:0]          color_i,
    output logic [STREAM_W-1:0] RGBStr_o,
    output logic [7:0]          frame_o
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    logic [CNT_W-1:0]    hcnt_q, hcnt_d;
    logic [CNT_W-1:0]    vcnt_q, vcnt_d;
    logic                wrapped_q, wrapped_d;
    logic [7:0]          frame_q, frame_d;
    logic [STREAM_W-1:0] stream_q, stream_d;
    logic                line_wrap, frame_wrap;
    logic                active, hs, vs;
    logic [RGB_W-1:0]    rgb;

    always_comb begin
        line_wrap  = (hcnt_q == CNT_W'(H_TOTAL - 1));
        frame_wrap = line_wrap && (vcnt_q == CNT_W'(V_TOTAL - 1));
        hcnt_d     = line_wrap ? '0 : hcnt_q + 1'b1;
        vcnt_d     = vcnt_q;
        if (line_wrap) begin
            vcnt_d = frame_wrap ? '0 : vcnt_q + 1'b1;
        end
        // The frame count steps on the edge after the wrap, i.e. when (0,0) is emitted.
        wrapped_d = frame_wrap;
        frame_d   = frame_q + {7'd0, wrapped_q};

        active = (hcnt_q < CNT_W'(H_VISIBLE)) && (vcnt_q < CNT_W'(V_VISIBLE));
        hs = (hcnt_q >= CNT_W'(HS_START) && hcnt_q <= CNT_W'(HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs = (vcnt_q >= CNT_W'(VS_START) && vcnt_q <= CNT_W'(VS_END)) ? SYNC_POL : ~SYNC_POL;
        stream_d = pack_stream(hs, vs, hcnt_q, vcnt_q, active, rgb);
    end

    pxs_pattern_gen #(
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE),
        .H_TOTAL   (H_TOTAL),
        .BAR_WIDTH (BAR_WIDTH),
        .CHECK_BIT (CHECK_BIT)
    ) u_pattern (
        .px_clk       (px_clk),
        .rst          (rst),
        .hcnt_i       (hcnt_q),
        .vcnt_i       (vcnt_q),
        .frame_wrap_i (frame_wrap),
        .frame_lsb_i  (frame_d[2:0]),
        .mode_i       (mode_i),
        .color_i      (color_i),
        .rgb_o        (rgb)
    );

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            wrapped_q <= 1'b0;
            frame_q   <= '0;
            stream_q  <= pack_stream(~SYNC_POL, ~SYNC_POL, '0, '0, 1'b0, COL_BLACK);
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            wrapped_q <= wrapped_d;
            frame_q   <= frame_d;
            stream_q  <= stream_d;
        end
    end

    assign RGBStr_o = stream_q;
    assign frame_o  = frame_q;

endmodule

// File: tb/tb_pxs_sync_gen.sv
// Bench for pxs_sync_gen: a reduced raster (80x30) instance checked against a
// scoreboard model every cycle, plus a default 800x525 instance for line timing.
module tb_pxs_sync_gen;
    import pxs_sync_gen_pkg::*;

    localparam int HV = 64, HF = 4, HSW = 8, HB = 4;
    localparam int VV = 24, VF = 2, VSW = 2, VB = 2;
    localparam int HT = HV + HF + HSW + HB;
    localparam int VT = VV + VF + VSW + VB;
    localparam int BW = 7, CB = 2;

    localparam logic [25:0] RESET_W = {1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 3'd0};
    localparam logic [25:0] FIRST_W = {1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 3'd0};

    typedef struct {
        logic [25:0] w;
        logic [7:0]  f;
    } exp_t;

    logic        px_clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode_i = 2'd1;
    logic [2:0]  color_i = 3'd0;
    logic [25:0] stream, stream_def;
    logic [7:0]  frame, frame_def;

    int   checks = 0;
    int   passes = 0;
    int   edge_n = 0;
    exp_t sb_q[$];

    always #5 px_clk = ~px_clk;

    pxs_sync_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .SYNC_POL(1'b0), .BAR_WIDTH(BW), .CHECK_BIT(CB)
    ) dut (
        .px_clk(px_clk), .rst(rst), .mode_i(mode_i), .color_i(color_i),
        .RGBStr_o(stream), .frame_o(frame)
    );

    pxs_sync_gen dut_def (
        .px_clk(px_clk), .rst(rst), .mode_i(mode_i), .color_i(color_i),
        .RGBStr_o(stream_def), .frame_o(frame_def)
    );

    // Reference model of the reduced instance: one expected word per clock edge.
    int          mh, mv;
    logic [1:0]  mmode;
    logic [2:0]  mcolor, m_rgb;
    logic [7:0]  mframe, m_fn;
    bit          mseen;
    logic [9:0]  m_x, m_y;
    logic        m_act;
    int          m_bar;
    exp_t        m_e;

    always @(posedge px_clk or posedge rst) begin
        if (rst) begin
            sb_q.delete();
            mh <= 0; mv <= 0; mmode <= 2'd0; mcolor <= 3'd0; mframe <= 8'd0; mseen <= 1'b0;
        end else begin
            m_fn  = (mh == 0 && mv == 0 && mseen) ? mframe + 8'd1 : mframe;
            m_x   = 10'(mh);
            m_y   = 10'(mv);
            m_act = (mh < HV) && (mv < VV);
            m_rgb = 3'd0;
            if (m_act) begin
                case (mmode)
                    2'd0: m_rgb = mcolor;
                    2'd1: begin
                        m_bar = mh / BW;
                        if (m_bar > 7) m_bar = 7;
                        m_rgb = 3'(m_bar);
                    end
                    2'd2: m_rgb = (m_x[CB] ^ m_y[CB]) ? 3'b111 : 3'b000;
                    default: m_rgb = m_x[5:3] + m_fn[2:0];
                endcase
            end
            m_e.w = {(mh >= HV + HF && mh < HV + HF + HSW) ? 1'b0 : 1'b1,
                     (mv >= VV + VF && mv < VV + VF + VSW) ? 1'b0 : 1'b1,
                     m_x, m_y, m_act, m_rgb};
            m_e.f = m_fn;
            sb_q.push_back(m_e);
            if (mh == HT - 1 && mv == VT - 1) begin
                mmode  <= mode_i;
                mcolor <= color_i;
            end
            mseen  <= 1'b1;
            mframe <= m_fn;
            if (mh == HT - 1) begin
                mh <= 0;
                mv <= (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh <= mh + 1;
            end
        end
    end

    task automatic tick(output exp_t e, output bit have);
        @(posedge px_clk);
        #1;
        edge_n++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            have = 1'b1;
        end else begin
            e.w = '0;
            e.f = '0;
            have = 1'b0;
        end
    endtask

    function automatic int xc_of(input logic [25:0] w);
        return int'(w[XC_LSB +: CNT_W]);
    endfunction

    function automatic int yc_of(input logic [25:0] w);
        return int'(w[YC_LSB +: CNT_W]);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        mode_i = 2'd1;
        color_i = 3'd0;
        repeat (3) @(posedge px_clk);
        #1;
        checks++; if (stream !== RESET_W) $display("[TB] FAIL reset_stream: got %h required %h", stream, RESET_W); else passes++;
        checks++; if (frame !== 8'd0) $display("[TB] FAIL reset_frame: got %0d required 0", frame); else passes++;
        checks++; if (stream_def !== RESET_W) $display("[TB] FAIL reset_stream_def: got %h required %h", stream_def, RESET_W); else passes++;
        @(negedge px_clk);
        rst = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_first_output();
        exp_t e;
        bit   have;
        tick(e, have);
        checks++; if (stream !== FIRST_W) $display("[TB] FAIL first_out: got %h required %h", stream, FIRST_W); else passes++;
        checks++; if (stream_def !== FIRST_W) $display("[TB] FAIL first_out_def: got %h required %h", stream_def, FIRST_W); else passes++;
        checks++; if (frame !== 8'd0) $display("[TB] FAIL first_frame: got %0d required 0", frame); else passes++;
        checks++; if (!have || stream !== e.w || frame !== e.f) $display("[TB] FAIL first_sb: got %h/%h required %h/%h", stream, frame, e.w, e.f); else passes++;
    endtask

    task automatic test_line_timing();
        exp_t e;
        bit   have, bad = 1'b0, prev_act = 1'b1;
        int   bad_edge = -1, fall_xc = -1, hs_low = 0, hs_first = -1, x0_b = -1, x0_c = -1, xc, yc;
        logic [33:0] got = '0, want = '0;
        for (int i = 0; i < 1600; i++) begin
            tick(e, have);
            xc = xc_of(stream_def);
            yc = yc_of(stream_def);
            if (prev_act && !stream_def[ACTIVE_BIT] && fall_xc < 0) fall_xc = xc;
            prev_act = stream_def[ACTIVE_BIT];
            if (yc == 0 && stream_def[HS_BIT] == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = xc;
            end
            if (xc == 0) begin
                if (x0_b < 0) x0_b = edge_n;
                else if (x0_c < 0) x0_c = edge_n;
            end
            if (!have || stream !== e.w || frame !== e.f) begin
                if (!bad) begin bad_edge = edge_n; got = {stream, frame}; want = {e.w, e.f}; end
                bad = 1'b1;
            end
        end
        checks++; if (fall_xc != 640) $display("[TB] FAIL active_fall_xc: got %0d required 640", fall_xc); else passes++;
        checks++; if (hs_low != 96) $display("[TB] FAIL hs_width: got %0d required 96", hs_low); else passes++;
        checks++; if (hs_first != 656) $display("[TB] FAIL hs_start: got %0d required 656", hs_first); else passes++;
        checks++; if (x0_b != 801) $display("[TB] FAIL line_period_1: got edge %0d required 801", x0_b); else passes++;
        checks++; if (x0_c != 1601) $display("[TB] FAIL line_period_2: got edge %0d required 1601", x0_c); else passes++;
        checks++; if (bad) $display("[TB] FAIL line_sb: edge %0d got %h required %h", bad_edge, got, want); else passes++;
    endtask

    task automatic test_frame_timing();
        exp_t e;
        bit   have, bad = 1'b0, done = 1'b0;
        int   bad_edge = -1, vs_low = 0, vs_misplaced = 0, rgb_lit = 0, yc;
        logic [33:0] got = '0, want = '0;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick(e, have);
            yc = yc_of(stream);
            if (xc_of(stream) == 0 && yc == 0) begin
                done = 1'b1;
            end else begin
                if (stream[VS_BIT] == 1'b0) vs_low++;
                if ((stream[VS_BIT] == 1'b0) != (yc >= VV + VF && yc < VV + VF + VSW)) vs_misplaced++;
                if (stream[RGB_LSB +: RGB_W] !== 3'd0) rgb_lit++;
            end
            if (!have || stream !== e.w || frame !== e.f) begin
                if (!bad) begin bad_edge = edge_n; got = {stream, frame}; want = {e.w, e.f}; end
                bad = 1'b1;
            end
        end
        checks++; if (!done) $display("[TB] FAIL frame_wrap_timeout: got no (0,0) required one"); else passes++;
        checks++; if (edge_n != HT * VT + 1) $display("[TB] FAIL frame_period: got edge %0d required %0d", edge_n, HT * VT + 1); else passes++;
        checks++; if (frame !== 8'd1) $display("[TB] FAIL frame_step: got %0d required 1", frame); else passes++;
        checks++; if (vs_low != VSW * HT) $display("[TB] FAIL vs_width: got %0d required %0d", vs_low, VSW * HT); else passes++;
        checks++; if (vs_misplaced != 0) $display("[TB] FAIL vs_rows: got %0d misplaced required 0", vs_misplaced); else passes++;
        checks++; if (rgb_lit != 0) $display("[TB] FAIL frame0_black: got %0d lit pixels required 0", rgb_lit); else passes++;
        checks++; if (bad) $display("[TB] FAIL frame_sb: edge %0d got %h required %h", bad_edge, got, want); else passes++;
    endtask

    task automatic test_bars();
        exp_t e;
        bit   have, bad = 1'b0, done = 1'b0;
        int   bad_edge = -1, xc, yc;
        logic [2:0]  r6 = 'x, r7 = 'x, r63 = 'x, r64 = 'x;
        logic [33:0] got = '0, want = '0;
        for (int i = 0; i < 2500 && !done; i++) begin
            tick(e, have);
            xc = xc_of(stream);
            yc = yc_of(stream);
            if (xc == 0 && yc == 12) mode_i = 2'd2;
            if (yc == 20) begin
                if (xc == 6) r6 = stream[RGB_LSB +: RGB_W];
                if (xc == 7) r7 = stream[RGB_LSB +: RGB_W];
                if (xc == 63) r63 = stream[RGB_LSB +: RGB_W];
                if (xc == 64) r64 = stream[RGB_LSB +: RGB_W];
            end
            if (xc == 0 && yc == 0) done = 1'b1;
            if (!have || stream !== e.w || frame !== e.f) begin
                if (!bad) begin bad_edge = edge_n; got = {stream, frame}; want = {e.w, e.f}; end
                bad = 1'b1;
            end
        end
        checks++; if (r6 !== 3'd0) $display("[TB] FAIL bar_x6: got %0d required 0", r6); else passes++;
        checks++; if (r7 !== 3'd1) $display("[TB] FAIL bar_x7: got %0d required 1", r7); else passes++;
        checks++; if (r63 !== 3'd7) $display("[TB] FAIL bar_x63_sat: got %0d required 7", r63); else passes++;
        checks++; if (r64 !== 3'd0) $display("[TB] FAIL bar_x64_blank: got %0d required 0", r64); else passes++;
        checks++; if (frame !== 8'd2) $display("[TB] FAIL bars_frame_end: got %0d required 2", frame); else passes++;
        checks++; if (bad) $display("[TB] FAIL bars_sb: edge %0d got %h required %h", bad_edge, got, want); else passes++;
    endtask

    task automatic test_checker();
        exp_t e;
        bit   have, bad = 1'b0, done = 1'b0;
        int   bad_edge = -1, xc, yc, blank_lit = 0;
        logic [2:0]  p30 = 'x, p40 = 'x, p44 = 'x, p023 = 'x;
        logic [33:0] got = '0, want = '0;
        for (int i = 0; i < 2500 && !done; i++) begin
            tick(e, have);
            xc = xc_of(stream);
            yc = yc_of(stream);
            if (xc == 0 && yc == 12) mode_i = 2'd3;
            if (xc == 3 && yc == 0) p30 = stream[RGB_LSB +: RGB_W];
            if (xc == 4 && yc == 0) p40 = stream[RGB_LSB +: RGB_W];
            if (xc == 4 && yc == 4) p44 = stream[RGB_LSB +: RGB_W];
            if (xc == 0 && yc == VV - 1) p023 = stream[RGB_LSB +: RGB_W];
            if (yc >= VV && stream[RGB_LSB +: RGB_W] !== 3'd0) blank_lit++;
            if (xc == 0 && yc == 0) done = 1'b1;
            if (!have || stream !== e.w || frame !== e.f) begin
                if (!bad) begin bad_edge = edge_n; got = {stream, frame}; want = {e.w, e.f}; end
                bad = 1'b1;
            end
        end
        checks++; if (p30 !== 3'd0) $display("[TB] FAIL chk_3_0: got %0d required 0", p30); else passes++;
        checks++; if (p40 !== 3'd7) $display("[TB] FAIL chk_4_0: got %0d required 7", p40); else passes++;
        checks++; if (p44 !== 3'd0) $display("[TB] FAIL chk_4_4: got %0d required 0", p44); else passes++;
        checks++; if (p023 !== 3'd7) $display("[TB] FAIL chk_0_last: got %0d required 7", p023); else passes++;
        checks++; if (blank_lit != 0) $display("[TB] FAIL chk_blank_rows: got %0d lit required 0", blank_lit); else passes++;
        checks++; if (stream[RGB_LSB +: RGB_W] !== 3'd3) $display("[TB] FAIL anim_origin: got %0d required 3", stream[RGB_LSB +: RGB_W]); else passes++;
        checks++; if (bad) $display("[TB] FAIL checker_sb: edge %0d got %h required %h", bad_edge, got, want); else passes++;
    endtask

    task automatic test_animated();
        exp_t e;
        bit   have, bad = 1'b0, done = 1'b0;
        int   bad_edge = -1, xc, yc;
        logic [2:0]  p85 = 'x, p630 = 'x;
        logic [33:0] got = '0, want = '0;
        for (int i = 0; i < 2500 && !done; i++) begin
            tick(e, have);
            xc = xc_of(stream);
            yc = yc_of(stream);
            if (xc == 0 && yc == 12) begin
                mode_i = 2'd0;
                color_i = COL_PINK;
            end
            if (xc == 8 && yc == 5) p85 = stream[RGB_LSB +: RGB_W];
            if (xc == 63 && yc == 0) p630 = stream[RGB_LSB +: RGB_W];
            if (xc == 0 && yc == 0) done = 1'b1;
            if (!have || stream !== e.w || frame !== e.f) begin
                if (!bad) begin bad_edge = edge_n; got = {stream, frame}; want = {e.w, e.f}; end
                bad = 1'b1;
            end
        end
        checks++; if (p85 !== 3'd4) $display("[TB] FAIL anim_8_5: got %0d required 4", p85); else passes++;
        checks++; if (p630 !== 3'd2) $display("[TB] FAIL anim_63_0_wrap: got %0d required 2", p630); else passes++;
        checks++; if (stream[RGB_LSB +: RGB_W] !== COL_PINK) $display("[TB] FAIL solid_colour: got %0d required 5", stream[RGB_LSB +: RGB_W]); else passes++;
        checks++; if (bad) $display("[TB] FAIL anim_sb: edge %0d got %h required %h", bad_edge, got, want); else passes++;
    endtask

    task automatic test_mid_reset();
        exp_t e;
        bit   have, bad = 1'b0, found = 1'b0;
        int   bad_edge = -1, lit = 0;
        logic [33:0] got = '0, want = '0;
        mode_i = 2'd2;
        for (int i = 0; i < 2500 && !found; i++) begin
            tick(e, have);
            if (xc_of(stream) == 30 && yc_of(stream) == 10) found = 1'b1;
        end
        checks++; if (!found) $display("[TB] FAIL midrst_reach: got no (30,10) required one"); else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (stream !== RESET_W) $display("[TB] FAIL midrst_async: got %h required %h", stream, RESET_W); else passes++;
        checks++; if (frame !== 8'd0) $display("[TB] FAIL midrst_frame: got %0d required 0", frame); else passes++;
        @(negedge px_clk);
        rst = 1'b0;
        edge_n = 0;
        tick(e, have);
        checks++; if (stream !== FIRST_W) $display("[TB] FAIL midrst_restart: got %h required %h", stream, FIRST_W); else passes++;
        for (int i = 0; i < HT; i++) begin
            if (stream[RGB_LSB +: RGB_W] !== 3'd0) lit++;
            if (!have || stream !== e.w || frame !== e.f) begin
                if (!bad) begin bad_edge = edge_n; got = {stream, frame}; want = {e.w, e.f}; end
                bad = 1'b1;
            end
            tick(e, have);
        end
        checks++; if (lit != 0) $display("[TB] FAIL midrst_mode0: got %0d lit required 0", lit); else passes++;
        checks++; if (bad) $display("[TB] FAIL midrst_sb: edge %0d got %h required %h", bad_edge, got, want); else passes++;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_first_output();
        test_line_timing();
        test_frame_timing();
        test_bars();
        test_checker();
        test_animated();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
